// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, NZVC flag bundle and branch condition encodings.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    typedef enum logic [2:0] {
        COND_EQ = 3'd0,
        COND_NE = 3'd1,
        COND_LT = 3'd2,
        COND_GE = 3'd3,
        COND_CS = 3'd4,
        COND_CC = 3'd5,
        COND_MI = 3'd6,
        COND_AL = 3'd7
    } cond_t;

    localparam int FLAGS_W = 4;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry in-order valid/ready buffer; slot p0 is the head, slot p1 the overflow entry.
module alu_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] data_p0, data_p1;
    logic             vld_p0, vld_p1;
    logic             push, pop;

    // ready is a pure function of occupancy so upstream never sees a combinational loop
    assign in_ready  = !vld_p1;
    assign push      = in_valid && in_ready;
    assign pop       = vld_p0 && out_ready;
    assign out_valid = vld_p0;
    assign out_data  = data_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p0 <= '0;
            data_p1 <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!vld_p0) begin
                        data_p0 <= in_data;
                        vld_p0  <= 1'b1;
                    end else begin
                        data_p1 <= in_data;
                        vld_p1  <= 1'b1;
                    end
                end
                2'b01: begin
                    data_p0 <= data_p1;
                    vld_p0  <= vld_p1;
                    vld_p1  <= 1'b0;
                end
                // push implies p1 empty, so push+pop simply replaces the head
                2'b11: data_p0 <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: skid-buffered result path, architectural NZVC register,
// branch condition evaluation and saturating signed-overflow statistics.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  alu_op_t                       in_op,
    input  logic signed [DATA_WIDTH-1:0]  in_result,
    input  logic                          in_z,
    input  logic                          in_n,
    input  logic                          in_v,
    input  logic                          in_c,
    input  logic                          in_set_flags,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_result,
    output flags_t                        out_flags,
    input  cond_t                         cond_sel,
    output logic                          cond_true,
    output flags_t                        nzvc,
    output logic [OVF_CNT_WIDTH-1:0]      ovf_count,
    output logic                          ovf_sticky,
    input  logic                          clr_sticky
);

    localparam int PW = DATA_WIDTH + FLAGS_W;
    localparam logic [OVF_CNT_WIDTH-1:0] CNT_ONE = {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [OVF_CNT_WIDTH-1:0] sat_inc(input logic [OVF_CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_ONE;
    endfunction

    logic [PW-1:0] in_payload, out_payload;
    logic          accept, ovf_evt;

    assign in_payload = {in_result, in_n, in_z, in_v, in_c};
    assign accept     = in_valid && in_ready;
    assign ovf_evt    = accept && in_v && (in_op == ALU_ADD || in_op == ALU_SUB);

    alu_skid_buf #(
        .WIDTH(PW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign out_result = out_payload[PW-1:FLAGS_W];
    assign out_flags  = out_payload[FLAGS_W-1:0];

    // status register tracks accepted ops, independent of when the consumer pops them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzvc <= '0;
        end else if (accept && in_set_flags) begin
            nzvc <= '{n: in_n, z: in_z, v: in_v, c: in_c};
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            COND_EQ: cond_true = nzvc.z;
            COND_NE: cond_true = !nzvc.z;
            COND_LT: cond_true = nzvc.n ^ nzvc.v;
            COND_GE: cond_true = !(nzvc.n ^ nzvc.v);
            COND_CS: cond_true = nzvc.c;
            COND_CC: cond_true = !nzvc.c;
            COND_MI: cond_true = nzvc.n;
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // an overflow in the same cycle as a clear restarts the count at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (ovf_evt) begin
            ovf_sticky <= 1'b1;
            ovf_count  <= clr_sticky ? CNT_ONE : sat_inc(ovf_count);
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (DATA_WIDTH=4, OVF_CNT_WIDTH=8).
module tb_alu_result_stage;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    alu_op_t           in_op;
    logic signed [3:0] in_result;
    logic              in_z, in_n, in_v, in_c, in_set_flags;
    logic              out_valid, out_ready;
    logic signed [3:0] out_result;
    flags_t            out_flags;
    cond_t             cond_sel;
    logic              cond_true;
    flags_t            nzvc;
    logic [7:0]        ovf_count;
    logic              ovf_sticky, clr_sticky;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_WIDTH(4), .OVF_CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_result(in_result), .in_z(in_z), .in_n(in_n),
        .in_v(in_v), .in_c(in_c), .in_set_flags(in_set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .cond_sel(cond_sel), .cond_true(cond_true),
        .nzvc(nzvc), .ovf_count(ovf_count), .ovf_sticky(ovf_sticky),
        .clr_sticky(clr_sticky)
    );

    task automatic drive(input alu_op_t op, input logic [3:0] res, input logic [3:0] f, input logic sf);
        in_valid     = 1'b1;
        in_op        = op;
        in_result    = res;
        {in_n, in_z, in_v, in_c} = f;
        in_set_flags = sf;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_op = ALU_ADD; in_result = '0;
        {in_n, in_z, in_v, in_c} = 4'b0000; in_set_flags = 1'b0;
        out_ready = 1'b0; cond_sel = COND_AL; clr_sticky = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_result !== 4'sd0) $display("FAIL reset_out_result got %0d want 0", out_result); else passed++;
        total++; if (nzvc !== 4'b0000) $display("FAIL reset_nzvc got %b want 0000", nzvc); else passed++;
        total++; if ({ovf_sticky, ovf_count} !== 9'd0) $display("FAIL reset_ovf got %b/%0d want 0/0", ovf_sticky, ovf_count); else passed++;
        @(negedge clk); rst_n = 1'b1; #1;
    endtask

    task automatic test_add_ovf;
        out_ready = 1'b1;
        drive(ALU_ADD, 4'b1000, 4'b1010, 1'b1);
        cond_sel = COND_LT;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL add_out_valid got %b want 1", out_valid); else passed++;
        total++; if (out_result !== -4'sd8) $display("FAIL add_out_result got %0d want -8", out_result); else passed++;
        total++; if (out_flags !== 4'b1010) $display("FAIL add_out_flags got %b want 1010", out_flags); else passed++;
        total++; if (nzvc !== 4'b1010) $display("FAIL add_nzvc got %b want 1010", nzvc); else passed++;
        total++; if (cond_true !== 1'b0) $display("FAIL add_cond_lt got %b want 0", cond_true); else passed++;
        cond_sel = COND_MI; #1;
        total++; if (cond_true !== 1'b1) $display("FAIL add_cond_mi got %b want 1", cond_true); else passed++;
        total++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) $display("FAIL add_ovf got %0d/%b want 1/1", ovf_count, ovf_sticky); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL add_popped got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        drive(ALU_AND, 4'd1, 4'b0001, 1'b0); tick();
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after1 got %b want 1", in_ready); else passed++;
        drive(ALU_AND, 4'd2, 4'b0010, 1'b0); tick();
        total++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_after2 got %b want 0", in_ready); else passed++;
        drive(ALU_OR, 4'd3, 4'b0100, 1'b0); tick(); tick();
        total++; if (out_result !== 4'sd1 || out_flags !== 4'b0001) $display("FAIL b2b_head_held got %0d/%b want 1/0001", out_result, out_flags); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL b2b_still_full got %b want 0", in_ready); else passed++;
        out_ready = 1'b1; tick();
        total++; if (out_result !== 4'sd2 || out_flags !== 4'b0010) $display("FAIL b2b_pop2 got %0d/%b want 2/0010", out_result, out_flags); else passed++;
        tick(); in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 4'sd3 || out_flags !== 4'b0100) $display("FAIL b2b_pop3 got %b/%0d/%b want 1/3/0100", out_valid, out_result, out_flags); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", out_valid); else passed++;
        total++; if (nzvc !== 4'b1010 || ovf_count !== 8'd1) $display("FAIL b2b_status_held got %b/%0d want 1010/1", nzvc, ovf_count); else passed++;
    endtask

    task automatic test_no_set_flags;
        out_ready = 1'b1;
        drive(ALU_OR, 4'd5, 4'b0000, 1'b1); tick();
        drive(ALU_SUB, 4'd0, 4'b0100, 1'b0); tick();
        in_valid = 1'b0; cond_sel = COND_EQ; #1;
        total++; if (nzvc !== 4'b0000) $display("FAIL nosf_nzvc got %b want 0000", nzvc); else passed++;
        total++; if (cond_true !== 1'b0) $display("FAIL nosf_cond_eq got %b want 0", cond_true); else passed++;
        total++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) $display("FAIL nosf_ovf got %0d/%b want 1/1", ovf_count, ovf_sticky); else passed++;
        tick();
    endtask

    task automatic test_ovf_saturate;
        out_ready = 1'b1;
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        total++; if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) $display("FAIL sat_clear got %0d/%b want 0/0", ovf_count, ovf_sticky); else passed++;
        for (int i = 0; i < 255; i++) begin
            drive((i % 2 == 0) ? ALU_ADD : ALU_SUB, 4'd7, 4'b0010, 1'b0);
            tick();
        end
        total++; if (ovf_count !== 8'hFF) $display("FAIL sat_reach got %0d want 255", ovf_count); else passed++;
        drive(ALU_ADD, 4'd7, 4'b0010, 1'b0); tick();
        total++; if (ovf_count !== 8'hFF) $display("FAIL sat_hold got %0d want 255", ovf_count); else passed++;
        clr_sticky = 1'b1; tick();
        clr_sticky = 1'b0; in_valid = 1'b0;
        total++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) $display("FAIL sat_clr_vs_evt got %0d/%b want 1/1", ovf_count, ovf_sticky); else passed++;
        tick();
    endtask

    task automatic test_ignore_v_and_conds;
        out_ready = 1'b1;
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        drive(ALU_AND, 4'd0, 4'b0111, 1'b1); tick();
        drive(ALU_XOR, 4'd0, 4'b0101, 1'b1); tick();
        in_valid = 1'b0;
        total++; if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) $display("FAIL ignv_ovf got %0d/%b want 0/0", ovf_count, ovf_sticky); else passed++;
        total++; if (nzvc !== 4'b0101) $display("FAIL ignv_nzvc got %b want 0101", nzvc); else passed++;
        for (int k = 0; k < 8; k++) begin
            logic exp;
            cond_sel = cond_t'(k);
            // nzvc = n0 z1 v0 c1
            case (k)
                0: exp = 1'b1; 1: exp = 1'b0; 2: exp = 1'b0; 3: exp = 1'b1;
                4: exp = 1'b1; 5: exp = 1'b0; 6: exp = 1'b0; default: exp = 1'b1;
            endcase
            #1;
            total++; if (cond_true !== exp) $display("FAIL cond_%0d got %b want %b", k, cond_true, exp); else passed++;
        end
        tick();
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        drive(ALU_ADD, 4'd4, 4'b1001, 1'b1); tick();
        drive(ALU_SUB, 4'd6, 4'b0010, 1'b1); tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL mrst_pre got %b/%b want 0/1", in_ready, out_valid); else passed++;
        #2 rst_n = 1'b0; #1;
        total++; if (out_valid !== 1'b0 || nzvc !== 4'b0000) $display("FAIL mrst_now got %b/%b want 0/0000", out_valid, nzvc); else passed++;
        total++; if (in_ready !== 1'b1 || ovf_count !== 8'd0 || ovf_sticky !== 1'b0) $display("FAIL mrst_ctrl got %b/%0d/%b want 1/0/0", in_ready, ovf_count, ovf_sticky); else passed++;
        @(negedge clk); rst_n = 1'b1;
        drive(ALU_OR, 4'd2, 4'b0100, 1'b0); tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 4'sd2 || out_flags !== 4'b0100) $display("FAIL mrst_after got %b/%0d/%b want 1/2/0100", out_valid, out_result, out_flags); else passed++;
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_back_to_back();
        test_no_set_flags();
        test_ovf_saturate();
        test_ignore_v_and_conds();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
